gcd_top: RTL and testbench
==========================

Name: gcd_top

Overview:
- Iterative GCD engine using subtraction-based Euclid over two unsigned operands.
- Operands are captured on a start pulse; one compare/subtract step runs per clock.
- Raises done and presents result when finished.
- Standalone compute block driven by a host controller through a simple start/done handshake.

Parameters:
- WIDTH, 16, bit width of operands, internal registers and result.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, active-low, asynchronous.
- start  input  1  request; sampled high on a rising edge in IDLE or DONE, it launches a computation.
- A_in  input  WIDTH  operand A, unsigned; sampled only on the accepting edge.
- B_in  input  WIDTH  operand B, unsigned; sampled only on the accepting edge.
- done  output  1  high while the FSM is in DONE.
- result  output  WIDTH  GCD of the last accepted operands; valid while done=1.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; clock port clk, reset port rst.
- Reset (rst=0, asynchronous): state=IDLE, internal A/B registers=0, done=0, result=0.
- FSM states and transitions:
  - IDLE → CALC on start=1; A_reg<=A_in, B_reg<=B_in.
  - CALC: one step per cycle, evaluated in priority order:
    - A_reg==0: result<=B_reg, go DONE.
    - B_reg==0: result<=A_reg, go DONE.
    - A_reg==B_reg: result<=A_reg, go DONE.
    - A_reg>B_reg: A_reg<=A_reg-B_reg, stay in CALC.
    - else: B_reg<=B_reg-A_reg, stay in CALC.
  - DONE: done=1, result held stable. start=1 → reload operands, done<=0, go CALC. Otherwise remain in DONE indefinitely.
- start while in CALC is ignored; operands are not resampled.
- A_in/B_in changes outside the accepting edge have no effect.
- Latency, start edge to done high: (number of subtraction steps + 1) cycles.
  - gcd(48,18): steps 30,18 → 12,18 → 12,6 → 6,6 → DONE; done high 5 cycles after the start edge.
- Zero operands: gcd(0,x)=x, gcd(x,0)=x, gcd(0,0)=0. No operand combination hangs.
- Arithmetic:
  - Subtraction is always larger minus smaller; no underflow or wrap.
  - All registers are WIDTH bits unsigned.
- Worst-case step count ≈ 2^WIDTH (e.g. gcd(65535,1)). No timeout.
- done and result are registered outputs; no combinational path from inputs.
- Reset asserted mid-computation aborts immediately to the reset values; a new start is required afterwards.
- start held high continuously:
  - accepted on entry edge from IDLE or DONE only;
  - on reaching DONE with start still high, the next edge restarts, so done pulses for 1 cycle.

Decomposition:
- Shared package gcd_pkg:
  - WIDTH default constant;
  - state enum typedef {IDLE, CALC, DONE}.
- One natural sub-module, gcd_datapath:
  - holds the A/B registers, comparator (eq, gt, zero flags) and subtractor;
  - driven by load/step controls from the FSM in gcd_top.
- Controller FSM, result register and done logic stay in gcd_top.

Test Plan:
- Reset with rst=0 for 2 cycles, then release → done=0, result=0. start with A=48, B=18 → done rises 5 cycles after the start edge, result=6.
- After the prior done, A=27, B=36, 1-cycle start pulse → done drops on the next edge, then result=9 with done=1.
- A=100, B=25 → result=25. A=7, B=3 → result=1. Each run holds done=1 and a stable result until the next start.
- Zero cases: (0,5)→5, (12,0)→12, (0,0)→0; each finishes 1 cycle after the start edge.
- Assert rst=0 asynchronously mid-CALC (A=65535, B=1) → done=0 and result=0 immediately, without a clock edge. Release reset and issue a new start (A=9, B=6) → result=3.
- Pulse start during CALC with different operands → ignored; the original operands' GCD is reported.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared definitions for the subtraction-based GCD engine.
package gcd_pkg;

  // Default operand / result width.
  localparam int GCD_WIDTH = 16;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } gcd_state_e;

  // True when a CALC step terminates: a zero operand or equal operands.
  function automatic logic gcd_finished(input logic a_zero,
                                        input logic b_zero,
                                        input logic eq);
    return a_zero | b_zero | eq;
  endfunction

endpackage

// File: rtl/gcd_datapath.sv
// Operand registers, comparator flags and larger-minus-smaller subtractor.
module gcd_datapath
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] a_val,
  output logic [WIDTH-1:0] b_val,
  output logic             a_zero,
  output logic             b_zero,
  output logic             eq,
  output logic             gt
);

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] diff_ab_s;
  logic [WIDTH-1:0] diff_ba_s;

  // Comparator flags and both subtraction directions; only the
  // non-underflowing one is ever written back.
  always_comb begin
    a_zero    = (a_r == {WIDTH{1'b0}});
    b_zero    = (b_r == {WIDTH{1'b0}});
    eq        = (a_r == b_r);
    gt        = (a_r > b_r);
    diff_ab_s = a_r - b_r;
    diff_ba_s = b_r - a_r;
  end

  // Operand registers: load new operands or reduce the larger one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r <= {WIDTH{1'b0}};
      b_r <= {WIDTH{1'b0}};
    end else if (load) begin
      a_r <= a_in;
      b_r <= b_in;
    end else if (step) begin
      if (gt) begin
        a_r <= diff_ab_s;
      end else begin
        b_r <= diff_ba_s;
      end
    end else begin
      a_r <= a_r;
      b_r <= b_r;
    end
  end

  assign a_val = a_r;
  assign b_val = b_r;

endmodule

// File: rtl/gcd_top.sv
// Iterative GCD engine: start/done handshake controller around the datapath.
module gcd_top
  import gcd_pkg::*;
#(
  parameter int WIDTH = GCD_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_in,
  input  logic [WIDTH-1:0] B_in,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  gcd_state_e       state_r;
  logic             done_r;
  logic [WIDTH-1:0] result_r;

  logic             load_s;
  logic             step_s;
  logic [WIDTH-1:0] a_val_s;
  logic [WIDTH-1:0] b_val_s;
  logic             a_zero_s;
  logic             b_zero_s;
  logic             eq_s;
  logic             gt_s;

  gcd_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk    (clk),
    .rst    (rst),
    .load   (load_s),
    .step   (step_s),
    .a_in   (A_in),
    .b_in   (B_in),
    .a_val  (a_val_s),
    .b_val  (b_val_s),
    .a_zero (a_zero_s),
    .b_zero (b_zero_s),
    .eq     (eq_s),
    .gt     (gt_s)
  );

  // Datapath controls: accept operands in IDLE/DONE, subtract while CALC is unfinished.
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    if ((state_r == IDLE) || (state_r == DONE)) begin
      load_s = start;
    end else if (state_r == CALC) begin
      step_s = ~gcd_finished(a_zero_s, b_zero_s, eq_s);
    end else begin
      load_s = 1'b0;
      step_s = 1'b0;
    end
  end

  // Controller FSM with registered done and result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= IDLE;
      done_r   <= 1'b0;
      result_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          done_r <= 1'b0;
          if (start) begin
            state_r <= CALC;
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          if (a_zero_s) begin
            result_r <= b_val_s;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else if (b_zero_s || eq_s) begin
            result_r <= a_val_s;
            done_r   <= 1'b1;
            state_r  <= DONE;
          end else begin
            done_r  <= 1'b0;
            state_r <= CALC;
          end
        end
        DONE: begin
          if (start) begin
            done_r  <= 1'b0;
            state_r <= CALC;
          end else begin
            done_r  <= 1'b1;
            state_r <= DONE;
          end
        end
        default: begin
          done_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign done   = done_r;
  assign result = result_r;

endmodule

// File: tb/tb_gcd_top.sv
// Directed self-checking bench for gcd_top.
module tb_gcd_top;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] A_in;
  logic [15:0] B_in;
  logic        done;
  logic [15:0] result;

  int vec_cnt;
  int err_cnt;

  gcd_top #(.WIDTH(16)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .A_in   (A_in),
    .B_in   (B_in),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands with start for exactly one accepting edge, then scramble inputs.
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    A_in  = a;
    B_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A_in  = 16'hDEAD;
    B_in  = 16'hBEEF;
  endtask

  // Count edges after the start edge until done is seen (bounded).
  task automatic wait_done(output int cyc);
    cyc = 0;
    while (done !== 1'b1 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_check(input string name, input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_res, input int exp_lat);
    int lat;
    launch(a, b);
    vec_cnt++;
    if (done !== 1'b0) begin
      err_cnt++;
      $display("FAIL %s done_after_start: got %0b want 0", name, done);
    end
    wait_done(lat);
    vec_cnt++;
    if (lat !== exp_lat) begin
      err_cnt++;
      $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
    end
    vec_cnt++;
    if (result !== exp_res) begin
      err_cnt++;
      $display("FAIL %s result: got %0d want %0d", name, result, exp_res);
    end
  endtask

  task automatic check_hold(input string name, input logic [15:0] exp_res);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      vec_cnt++;
      if (done !== 1'b1 || result !== exp_res) begin
        err_cnt++;
        $display("FAIL %s hold[%0d]: got done=%0b result=%0d want done=1 result=%0d",
                 name, i, done, result, exp_res);
      end
    end
  endtask

  task automatic test_reset;
    rst   = 1'b0;
    start = 1'b0;
    A_in  = 16'd0;
    B_in  = 16'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0 || result !== 16'd0) begin
      err_cnt++;
      $display("FAIL reset_active: got done=%0b result=%0d want 0/0", done, result);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (done !== 1'b0 || result !== 16'd0) begin
      err_cnt++;
      $display("FAIL reset_release: got done=%0b result=%0d want 0/0", done, result);
    end
  endtask

  task automatic test_basic;
    run_check("gcd_48_18", 16'd48, 16'd18, 16'd6, 5);
  endtask

  task automatic test_restart;
    run_check("gcd_27_36", 16'd27, 16'd36, 16'd9, 4);
  endtask

  task automatic test_hold;
    run_check("gcd_100_25", 16'd100, 16'd25, 16'd25, 4);
    check_hold("gcd_100_25", 16'd25);
    run_check("gcd_7_3", 16'd7, 16'd3, 16'd1, 5);
    check_hold("gcd_7_3", 16'd1);
  endtask

  task automatic test_zero;
    run_check("gcd_0_5", 16'd0, 16'd5, 16'd5, 1);
    run_check("gcd_12_0", 16'd12, 16'd0, 16'd12, 1);
    run_check("gcd_0_0", 16'd0, 16'd0, 16'd0, 1);
  endtask

  // start held high: accept, DONE for one cycle, restart, DONE again.
  task automatic test_start_held;
    logic [3:0] seen;
    logic [3:0] want;
    want = 4'b1010;
    @(negedge clk);
    A_in  = 16'd0;
    B_in  = 16'd5;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      seen[i] = done;
    end
    start = 1'b0;
    @(posedge clk);
    #1;
    seen[3] = done;
    vec_cnt++;
    if (seen !== want || result !== 16'd5) begin
      err_cnt++;
      $display("FAIL start_held: got done_seq=%b result=%0d want done_seq=%b result=5",
               seen, result, want);
    end
  endtask

  task automatic test_ignore_start;
    int lat;
    launch(16'd48, 16'd18);
    @(negedge clk);
    A_in  = 16'd100;
    B_in  = 16'd25;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(lat);
    lat = lat + 1;
    vec_cnt++;
    if (lat !== 5) begin
      err_cnt++;
      $display("FAIL ignore_start latency: got %0d want 5", lat);
    end
    vec_cnt++;
    if (result !== 16'd6) begin
      err_cnt++;
      $display("FAIL ignore_start result: got %0d want 6", result);
    end
  endtask

  task automatic test_async_reset;
    launch(16'd65535, 16'd1);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (done !== 1'b0 || result !== 16'd0) begin
      err_cnt++;
      $display("FAIL async_reset: got done=%0b result=%0d want 0/0", done, result);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    vec_cnt++;
    if (done !== 1'b0 || result !== 16'd0) begin
      err_cnt++;
      $display("FAIL post_reset_idle: got done=%0b result=%0d want 0/0", done, result);
    end
    run_check("gcd_9_6", 16'd9, 16'd6, 16'd3, 3);
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_basic();
    test_restart();
    test_hold();
    test_zero();
    test_start_held();
    test_ignore_start();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
